seq_bin_to_bcd: RTL

//   Iterative (shift-add-3, one bit per clock) binary-to-BCD converter for multiplier/ALU results.

---
 rtl/bcd_pkg.sv | 32 +++
 rtl/bcd_dabble_cell.sv | 13 +
 rtl/seq_bin_to_bcd.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } b2b_state_t;

  localparam int BCD_ADJ_THRESH = 4;
  localparam int BCD_ADJ_ADD    = 3;

  // Decimal digits needed to represent 2^width-1 without overflow.
  function automatic int bcd_min_digits(input int width);
    longint unsigned maxv;
    longint unsigned pow10;
    int              d;
    maxv  = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    d     = 1;
    pow10 = 64'd10;
    for (int i = 0; i < 19; i++) begin
      if (maxv >= pow10) begin
        d++;
        pow10 = pow10 * 64'd10;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_dabble_cell.sv
// One BCD digit of the double-dabble adjust step: digits above 4 get +3, no carry out.
module bcd_dabble_cell
  import bcd_pkg::*;
(
  input  bcd_digit_t digit_i,
  output bcd_digit_t digit_o
);

  assign digit_o = (digit_i > bcd_digit_t'(BCD_ADJ_THRESH))
                 ? bcd_digit_t'(digit_i + bcd_digit_t'(BCD_ADJ_ADD))
                 : digit_i;

endmodule

// File: rtl/seq_bin_to_bcd.sv
// Iterative shift-add-3 binary-to-BCD converter, one input bit per clock, valid/ready on both sides.
// Define BIN2BCD_SIGNED_EN to treat in_bin as two's complement and expose out_neg.
module seq_bin_to_bcd
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIN_W-1:0]    in_bin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_bcd,
  output logic                out_ovf
`ifdef BIN2BCD_SIGNED_EN
  ,
  output logic                out_neg
`endif
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  b2b_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic             ovf_q, ovf_d;
  logic [BCD_W-1:0] out_bcd_q, out_bcd_d;
  logic             out_ovf_q, out_ovf_d;
  logic [BCD_W-1:0] bcd_adj;
  logic [SR_W-1:0]  sr_adj;
  logic [BIN_W-1:0] mag;
  logic             last_shift;

  for (genvar g = 0; g < DIGITS; g++) begin : g_cell
    bcd_dabble_cell u_cell (
      .digit_i (sr_q[BIN_W + 4*g +: 4]),
      .digit_o (bcd_adj[4*g +: 4])
    );
  end

  assign sr_adj     = {bcd_adj, sr_q[BIN_W-1:0]};
  assign last_shift = (cnt_q == CNT_W'(BIN_W - 1));

`ifdef BIN2BCD_SIGNED_EN
  logic neg_q, neg_d;
  logic out_neg_q, out_neg_d;
  // Negating -2^(BIN_W-1) wraps to itself, which reads correctly as an unsigned magnitude.
  assign mag = in_bin[BIN_W-1] ? BIN_W'(~in_bin + 1'b1) : in_bin;
`else
  assign mag = in_bin;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    ovf_d     = ovf_q;
    out_bcd_d = out_bcd_q;
    out_ovf_d = out_ovf_q;
`ifdef BIN2BCD_SIGNED_EN
    neg_d     = neg_q;
    out_neg_d = out_neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sr_d    = {{BCD_W{1'b0}}, mag};
          ovf_d   = 1'b0;
          cnt_d   = '0;
`ifdef BIN2BCD_SIGNED_EN
          neg_d   = in_bin[BIN_W-1];
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = {sr_adj[SR_W-2:0], 1'b0};
        // Any bit pushed out of the top digit means the value needs more digits.
        ovf_d = ovf_q | sr_adj[SR_W-1];
        cnt_d = cnt_q + 1'b1;
        if (last_shift) begin
          state_d   = DONE;
          out_bcd_d = sr_d[SR_W-1 -: BCD_W];
          out_ovf_d = ovf_d;
`ifdef BIN2BCD_SIGNED_EN
          out_neg_d = neg_q;
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      ovf_q     <= 1'b0;
      out_bcd_q <= '0;
      out_ovf_q <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
      neg_q     <= 1'b0;
      out_neg_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      ovf_q     <= ovf_d;
      out_bcd_q <= out_bcd_d;
      out_ovf_q <= out_ovf_d;
`ifdef BIN2BCD_SIGNED_EN
      neg_q     <= neg_d;
      out_neg_q <= out_neg_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_bcd   = out_bcd_q;
  assign out_ovf   = out_ovf_q;
`ifdef BIN2BCD_SIGNED_EN
  assign out_neg   = out_neg_q;
`endif

  // With enough digits for the full input range, overflow is impossible.
  a_no_ovf_when_wide: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && (DIGITS >= bcd_min_digits(BIN_W))) |-> !out_ovf);

endmodule
